// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: default register-file geometry and the
// register address/data types used by the issue and writeback stages.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/regfile_multiport_if.sv
// Register-file bus: two writeback ports, packed read ports with busy flags,
// destination reserve and a debug read port.
interface regfile_multiport_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = 2
);

   logic                     we0;
   logic [ADDR_W-1:0]        waddr0;
   logic [DATA_W-1:0]        wdata0;
   logic                     we1;
   logic [ADDR_W-1:0]        waddr1;
   logic [DATA_W-1:0]        wdata1;
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rbusy;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;
   logic [ADDR_W-1:0]        dbg_addr;
   logic [DATA_W-1:0]        dbg_data;

   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1,
      output raddr, rsv_en, rsv_addr, dbg_addr,
      input  rdata, rbusy, dbg_data
   );

   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1,
      input  raddr, rsv_en, rsv_addr, dbg_addr,
      output rdata, rbusy, dbg_data
   );

endinterface : regfile_multiport_if

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for issue-stage hazard detection: writes clear,
// reserves set, and a reserve beats a write to the same register.
module regfile_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        waddr0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        waddr1,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD-1:0]        rbusy
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;

   // Reserve is applied last so the newer pending producer wins over a retiring one.
   always_comb begin
      busy_next = busy;
      if (we0)    busy_next[waddr0]   = 1'b0;
      if (we1)    busy_next[waddr1]   = 1'b0;
      if (rsv_en) busy_next[rsv_addr] = 1'b1;
      if (ZERO_REG != 0) busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) busy <= '0;
      else       busy <= busy_next;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
      logic [ADDR_W-1:0] a;
      logic              wr_hit;
      assign a      = raddr[k*ADDR_W +: ADDR_W];
      assign wr_hit = (we0 && waddr0 == a) || (we1 && waddr1 == a);
      assign rbusy[k] = busy[a] && !((BYPASS != 0) && wr_hit);
   end

endmodule : regfile_scoreboard

// File: rtl/regfile_multiport.sv
// Multiport general-purpose register file: N combinational read ports with
// optional bypass, two prioritised write ports, busy scoreboard, debug read.
module regfile_multiport
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clock,
   input  logic          reset,
   regfile_multiport_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr0_ok;
   logic              wr1_ok;

   assign wr0_ok = bus.we0 && !((ZERO_REG != 0) && bus.waddr0 == '0);
   assign wr1_ok = bus.we1 && !((ZERO_REG != 0) && bus.waddr1 == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the whole array is cleared on reset, so it maps to flops rather than RAM.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr0_ok) mem[bus.waddr0] <= bus.wdata0;
         // NOTE: the later non-blocking assignment wins on an address collision.
         if (wr1_ok) mem[bus.waddr1] <= bus.wdata1;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] rd;
      assign a = bus.raddr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rd = mem[a];
         if ((BYPASS != 0) && bus.we0 && bus.waddr0 == a) rd = bus.wdata0;
         if ((BYPASS != 0) && bus.we1 && bus.waddr1 == a) rd = bus.wdata1;
         if ((ZERO_REG != 0) && a == '0)                  rd = '0;
      end

      assign bus.rdata[k*DATA_W +: DATA_W] = rd;
   end

   assign bus.dbg_data = mem[bus.dbg_addr];

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clock    (clock),
      .reset    (reset),
      .we0      (bus.we0),
      .waddr0   (bus.waddr0),
      .we1      (bus.we1),
      .waddr1   (bus.waddr1),
      .rsv_en   (bus.rsv_en),
      .rsv_addr (bus.rsv_addr),
      .raddr    (bus.raddr),
      .rbusy    (bus.rbusy)
   );

endmodule : regfile_multiport

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised general-purpose register file for the pipelined CPU core. It replaces the single-write, negative-edge register file. It provides:
- N combinational read ports;
- two rising-edge write ports with fixed priority;
- optional write-to-read bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard that the issue stage uses for hazard detection.

A debug read port replaces the per-register output buses.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- we0  in  1  write enable, port 0 (ALU writeback)
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (memory writeback, higher priority)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data, combinational
- rbusy  out  NUM_RD  busy flag of each read address, combinational
- rsv_en  in  1  reserve request; marks a destination pending
- rsv_addr  in  ADDR_W  register to reserve
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data; storage value only, never bypassed

## Operation
Reset:
- When reset=1 at a rising edge, all storage words clear to 0 and all busy bits clear to 0.
- Reset dominates every write and reserve in that cycle.

Writes (rising edge, reset=0):
- we0 writes wdata0 to waddr0.
- we1 writes wdata1 to waddr1.
- Same address with both enables set: port 1 wins; the port 0 value is discarded.
- ZERO_REG=1: writes to address 0 are dropped.

Read data, per port k, with a = raddr[k]:
- ZERO_REG=1 and a=0: rdata is 0.
- Otherwise, BYPASS=1 and we1 with waddr1=a: rdata is wdata1.
- Otherwise, BYPASS=1 and we0 with waddr0=a: rdata is wdata0.
- Otherwise: rdata is the storage word at a.
- Bypass is active while reset=1 only if the enables are asserted. The bench holds the enables at 0 during reset.

Scoreboard (rising edge, reset=0):
- Any write to address a clears busy[a].
- rsv_en sets busy[rsv_addr].
- A reserve and a write to the same address in one cycle: the reserve wins and busy ends at 1, because the newer producer is pending.
- ZERO_REG=1: busy[0] is constant 0.

Busy read:
- rbusy[k] = busy[raddr[k]], with a bypass:
  - a same-cycle write to raddr[k] forces rbusy[k]=0 when BYPASS=1;
  - a same-cycle reserve to raddr[k] does not affect rbusy[k] until the next cycle.
- When BYPASS=0, rbusy[k] is the raw busy bit.

## Timing
- Read data and busy flags: combinational from raddr and the current state; zero-cycle latency.
- Write to read:
  - BYPASS=1: the new value is visible in the same cycle via bypass, then from storage on the next cycle.
  - BYPASS=0: the new value is visible on the cycle after the edge.
- Reserve to busy: rbusy rises on the cycle after the edge that samples rsv_en.
- Reset: one edge with reset=1 zeroes everything. rdata, rbusy and dbg_data read 0 in the cycle after that edge while enables are low.
- There is no handshake; writes and reserves are unconditional single-cycle pulses.

## Structure
- Shared package cpu_pkg holds:
  - the constants DATA_W_DEF=32 and ADDR_W_DEF=5;
  - the reg_addr_t and reg_data_t typedefs.
- The scoreboard is a natural sub-module: regfile_scoreboard (busy vector, reserve/clear logic, reserve-wins rule).
- The read mux with bypass is generated per read port inside regfile_multiport.

## Test plan
- Reset clear: preload r5=0xDEADBEEF and reserve r5, then assert reset for 1 cycle -> rdata(r5)=0, rbusy=0, dbg_data(r5)=0.
- Dual-write collision: we0 and we1 both to r7, wdata0=0x11, wdata1=0x22 -> next cycle rdata(r7)=0x22. With BYPASS=1, same-cycle rdata also =0x22.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0 -> rdata(r0)=0, rbusy=0 on every cycle. Repeat with ZERO_REG=0 -> rdata(r0)=0xFFFFFFFF.
- Bypass on/off: write r3=0x1234 and read r3 in the same cycle. BYPASS=1 -> 0x1234 immediately. BYPASS=0 -> old value (0), then 0x1234 on the next cycle.
- Scoreboard race:
  - reserve r9 (rbusy=1 next cycle);
  - then write r9 and reserve r9 in the same cycle -> busy stays 1;
  - then write r9 alone -> rbusy=0 in the same cycle (bypass) and busy=0 afterwards.
- Multiport sweep with NUM_RD=4:
  - write rk=k*0x100 for all 32 registers;
  - read four distinct addresses per cycle -> each rdata slice matches;
  - dbg_data matches for every address.
